// File: rtl/onectr_pkg.sv
// Shared types and constants for the ones-counter datapath.
package onectr_pkg;

    localparam int NREGS = 16;
    localparam int ADDRW = $clog2(NREGS);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHR  = 3'b110,
        OP_LSB  = 3'b111
    } op_t;

    // Values 4..15 of the select field are NOPs and have no enum member.
    typedef enum logic [3:0] {
        SEL_ALU = 4'h0,
        SEL_IN  = 4'h1,
        SEL_IMM = 4'h2,
        SEL_OUT = 4'h3
    } sel_t;

endpackage

// File: rtl/onectr_regfile.sv
// 16-entry register file: two combinational read ports, one synchronous write port.
// A read of the address being written returns the old contents; the new value
// appears on the following cycle.
module onectr_regfile
    import onectr_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ADDRW-1:0] wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [ADDRW-1:0] raa,
    input  logic [ADDRW-1:0] rab,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdb
);

    logic [WIDTH-1:0] regs [NREGS];

    // Clear every entry on reset, otherwise perform the single write port update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen) begin
            regs[wa] <= wd;
        end
    end

    assign rda = regs[raa];
    assign rdb = regs[rab];

endmodule

// File: rtl/onectr_nomem_datapath.sv
// Datapath of the no-memory ones-counter: register file, ALU, zero flag,
// input latch and output register, executing one control word per clock.
module onectr_nomem_datapath
    import onectr_pkg::*;
#(
    parameter  int INPUTSIZE = 64,
    localparam int OUTSIZE   = $clog2(INPUTSIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [INPUTSIZE-1:0] InPort,
    input  logic [7:0]           Ctrl,
    input  logic [3:0]           Sel,
    input  logic                 Wen,
    input  logic [3:0]           WA,
    input  logic [3:0]           RAA,
    input  logic [3:0]           RAB,
    input  logic [2:0]           Op,
    output logic                 Flag,
    output logic [OUTSIZE-1:0]   OutPort
);

    logic [INPUTSIZE-1:0] a;
    logic [INPUTSIZE-1:0] b;
    logic [INPUTSIZE-1:0] alu_result;
    logic [INPUTSIZE-1:0] in_reg;
    logic [INPUTSIZE-1:0] imm;
    logic [INPUTSIZE-1:0] wr_data;
    logic                 rf_wen;
    logic                 alu_write;

    assign imm       = {{(INPUTSIZE-8){1'b0}}, Ctrl};
    assign alu_write = Wen && (Sel == SEL_ALU);

    onectr_regfile #(
        .WIDTH (INPUTSIZE)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .wen (rf_wen),
        .wa  (WA),
        .wd  (wr_data),
        .raa (RAA),
        .rab (RAB),
        .rda (a),
        .rdb (b)
    );

    // ALU: all results wrap at the word width.
    always_comb begin
        alu_result = '0;
        case (op_t'(Op))
            OP_PASS: alu_result = a;
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_SHR:  alu_result = a >> 1;
            OP_LSB:  alu_result = {{(INPUTSIZE-1){1'b0}}, a[0]};
            default: alu_result = '0;
        endcase
    end

    // Write-back source mux; only the three register-writing selects may write.
    always_comb begin
        wr_data = alu_result;
        rf_wen  = 1'b0;
        case (Sel)
            SEL_ALU: begin
                wr_data = alu_result;
                rf_wen  = Wen;
            end
            SEL_IN: begin
                wr_data = in_reg;
                rf_wen  = Wen;
            end
            SEL_IMM: begin
                wr_data = imm;
                rf_wen  = Wen;
            end
            default: begin
                wr_data = alu_result;
                rf_wen  = 1'b0;
            end
        endcase
    end

    // Input latch, zero flag and output register share the same reset and clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg  <= '0;
            Flag    <= 1'b0;
            OutPort <= '0;
        end else begin
            if (start_i) begin
                in_reg <= InPort;
            end
            if (alu_write) begin
                Flag <= (alu_result == '0);
            end
            if (Sel == SEL_OUT) begin
                OutPort <= a[OUTSIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_onectr_nomem_datapath.sv
// Directed self-checking bench for the ones-counter datapath.
module tb_onectr_nomem_datapath;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [63:0] InPort;
    logic [7:0]  Ctrl;
    logic [3:0]  Sel;
    logic        Wen;
    logic [3:0]  WA;
    logic [3:0]  RAA;
    logic [3:0]  RAB;
    logic [2:0]  Op;
    logic        Flag;
    logic [6:0]  OutPort;

    int checkCount = 0;
    int failCount  = 0;

    onectr_nomem_datapath #(
        .INPUTSIZE (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .InPort  (InPort),
        .Ctrl    (Ctrl),
        .Sel     (Sel),
        .Wen     (Wen),
        .WA      (WA),
        .RAA     (RAA),
        .RAB     (RAB),
        .Op      (Op),
        .Flag    (Flag),
        .OutPort (OutPort)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one control word, let one rising edge pass, then settle.
    task automatic applyStimulus(input logic [3:0] sel, input logic wen, input logic [3:0] wa,
                                 input logic [3:0] raa, input logic [3:0] rab, input logic [2:0] op,
                                 input logic [7:0] ctrl, input logic start);
        Sel     = sel;
        Wen     = wen;
        WA      = wa;
        RAA     = raa;
        RAB     = rab;
        Op      = op;
        Ctrl    = ctrl;
        start_i = start;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        Wen     = 1'b0;
        Sel     = 4'h4;
    endtask

    task automatic writeImm(input logic [3:0] wa, input logic [7:0] val);
        applyStimulus(4'h2, 1'b1, wa, 4'h0, 4'h0, 3'b000, val, 1'b0);
    endtask

    task automatic aluOp(input logic [2:0] op, input logic [3:0] wa, input logic [3:0] raa, input logic [3:0] rab);
        applyStimulus(4'h0, 1'b1, wa, raa, rab, op, 8'h00, 1'b0);
    endtask

    task automatic loadInput(input logic [63:0] val);
        InPort = val;
        applyStimulus(4'h4, 1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 8'h00, 1'b1);
    endtask

    task automatic checkReg(input string tag, input logic [3:0] r, input logic [6:0] expected);
        applyStimulus(4'h3, 1'b0, 4'h0, r, 4'h0, 3'b000, 8'h00, 1'b0);
        checkOutput(tag, {57'd0, OutPort}, {57'd0, expected});
    endtask

    task automatic aluCheck(input string tag, input logic [2:0] op, input logic [3:0] raa,
                            input logic [3:0] rab, input logic [6:0] expected, input logic expFlag);
        aluOp(op, 4'd10, raa, rab);
        checkOutput({tag, "_flag"}, {63'd0, Flag}, {63'd0, expFlag});
        checkReg(tag, 4'd10, expected);
    endtask

    // Bench-driven ones-count: R0 accumulates LSBs of R2 while R2 shifts right.
    task automatic runOnesCount(input string tag, input logic [63:0] val, input logic [6:0] expected);
        loadInput(val);
        applyStimulus(4'h1, 1'b1, 4'd2, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        writeImm(4'd0, 8'h00);
        for (int i = 0; i < 64; i++) begin
            aluOp(3'b111, 4'd4, 4'd2, 4'd0);
            aluOp(3'b001, 4'd0, 4'd0, 4'd4);
            aluOp(3'b110, 4'd2, 4'd2, 4'd0);
        end
        checkOutput({tag, "_zero_flag"}, {63'd0, Flag}, 64'd1);
        checkReg(tag, 4'd0, expected);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        InPort  = '0;
        Ctrl    = '0;
        Sel     = 4'h4;
        Wen     = 1'b0;
        WA      = '0;
        RAA     = '0;
        RAB     = '0;
        Op      = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_flag", {63'd0, Flag}, 64'd0);
        checkOutput("reset_out", {57'd0, OutPort}, 64'd0);
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            checkReg($sformatf("reset_r%0d", r), 4'(r), 7'd0);
        end

        // Input latch path and LSB extract.
        loadInput(64'h0000_0000_0000_00FF);
        applyStimulus(4'h1, 1'b1, 4'd2, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        checkReg("in_to_r2", 4'd2, 7'h7F);
        aluOp(3'b111, 4'd6, 4'd2, 4'd0);
        checkOutput("lsb_flag", {63'd0, Flag}, 64'd0);
        checkReg("lsb_r6", 4'd6, 7'd1);

        // InPort changes without start_i must not reach the latch.
        InPort = 64'h55;
        applyStimulus(4'h1, 1'b1, 4'd7, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        checkReg("inport_ignored", 4'd7, 7'h7F);

        // start_i together with an input write stores the previous latch value.
        InPort = 64'h0F;
        applyStimulus(4'h1, 1'b1, 4'd8, 4'h0, 4'h0, 3'b000, 8'h00, 1'b1);
        checkReg("start_same_cycle_old", 4'd8, 7'h7F);
        applyStimulus(4'h1, 1'b1, 4'd9, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        checkReg("start_same_cycle_new", 4'd9, 7'h0F);

        // Countdown: flag rises only when R3 reaches zero, then R3 wraps.
        writeImm(4'd1, 8'h01);
        writeImm(4'd3, 8'h05);
        for (int i = 1; i <= 6; i++) begin
            aluOp(3'b010, 4'd3, 4'd3, 4'd1);
            checkOutput($sformatf("sub_flag_%0d", i), {63'd0, Flag}, (i == 5) ? 64'd1 : 64'd0);
        end
        checkReg("sub_wrap", 4'd3, 7'h7F);

        // Every ALU op with R11=0x2C, R12=0x17.
        writeImm(4'd11, 8'h2C);
        writeImm(4'd12, 8'h17);
        aluCheck("op_pass", 3'b000, 4'd11, 4'd12, 7'h2C, 1'b0);
        aluCheck("op_add",  3'b001, 4'd11, 4'd12, 7'h43, 1'b0);
        aluCheck("op_sub",  3'b010, 4'd11, 4'd12, 7'h15, 1'b0);
        aluCheck("op_subw", 3'b010, 4'd12, 4'd11, 7'h6B, 1'b0);
        aluCheck("op_and",  3'b011, 4'd11, 4'd12, 7'h04, 1'b0);
        aluCheck("op_or",   3'b100, 4'd11, 4'd12, 7'h3F, 1'b0);
        aluCheck("op_xor",  3'b101, 4'd11, 4'd12, 7'h3B, 1'b0);
        aluCheck("op_shr",  3'b110, 4'd11, 4'd12, 7'h16, 1'b0);
        aluCheck("op_lsb",  3'b111, 4'd11, 4'd12, 7'h00, 1'b1);
        aluCheck("op_lsb1", 3'b111, 4'd12, 4'd11, 7'h01, 1'b0);

        // Full ones-count program on several words.
        runOnesCount("ones_all", 64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
        runOnesCount("ones_zero", 64'h0, 7'd0);
        runOnesCount("ones_mix", 64'h8000_0001_F0F0_0003, 7'd12);

        // Read-during-write: the writing cycle still sees the old R4.
        writeImm(4'd4, 8'h07);
        aluOp(3'b001, 4'd4, 4'd4, 4'd1);
        checkReg("rdw_add", 4'd4, 7'd8);
        writeImm(4'd4, 8'h09);
        aluOp(3'b000, 4'd14, 4'd4, 4'd0);
        checkReg("rdw_next", 4'd14, 7'd9);

        // NOP selects and Wen=0 leave registers, flag and output untouched.
        writeImm(4'd5, 8'h34);
        aluOp(3'b010, 4'd15, 4'd1, 4'd1);
        checkOutput("nop_pre_flag", {63'd0, Flag}, 64'd1);
        checkReg("nop_pre_r5", 4'd5, 7'h34);
        for (int s = 4; s < 16; s++) begin
            applyStimulus(4'(s), 1'b1, 4'd5, 4'd11, 4'd12, 3'b001, 8'h77, 1'b0);
        end
        checkOutput("nop_flag", {63'd0, Flag}, 64'd1);
        checkOutput("nop_out_hold", {57'd0, OutPort}, 64'h34);
        applyStimulus(4'h0, 1'b0, 4'd5, 4'd11, 4'd12, 3'b001, 8'h00, 1'b0);
        checkOutput("wen0_flag", {63'd0, Flag}, 64'd1);
        checkReg("nop_r5", 4'd5, 7'h34);

        // Reset in the middle of a program discards everything.
        loadInput(64'h1234);
        applyStimulus(4'h1, 1'b1, 4'd5, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        checkReg("pre_rst_r5", 4'd5, 7'h34);
        writeImm(4'd6, 8'd12);
        checkReg("pre_rst_out", 4'd6, 7'd12);
        aluOp(3'b010, 4'd15, 4'd1, 4'd1);
        rst = 1'b1;
        applyStimulus(4'h2, 1'b1, 4'd7, 4'd6, 4'h0, 3'b000, 8'h55, 1'b1);
        rst = 1'b0;
        checkOutput("rst_flag", {63'd0, Flag}, 64'd0);
        checkOutput("rst_out", {57'd0, OutPort}, 64'd0);
        checkReg("rst_r5", 4'd5, 7'd0);
        checkReg("rst_r6", 4'd6, 7'd0);
        checkReg("rst_r7", 4'd7, 7'd0);
        applyStimulus(4'h1, 1'b1, 4'd8, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
        checkReg("rst_inreg", 4'd8, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
